if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the program counter, reads a word-addressed instruction memory, and registers the fetched word into the IF/ID pipeline register that feeds the decode stage. It takes redirect information back from decode (Jump, 26-bit target) and from execute (taken branch, 32-bit target), and handles stall holds and flush bubbles. It is the producer for the decode stage's `ID_Inst` input.

## Interface
- `IMEM_DEPTH`, 256: number of 32-bit instruction words; must be a power of two.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CLK`  in  1: single clock; every register updates on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Stall`  in  1: hazard hold; PC and IF/ID keep their values.
- `Jump`  in  1: jump decoded in ID this cycle.
- `target`  in  26: jump target field from the ID instruction.
- `Branch_Taken`  in  1: branch resolved as taken in EX this cycle.
- `Branch_PC`  in  32: branch destination computed in EX.
- `ImemWe`  in  1: program-load write enable.
- `ImemAddr`  in  log2(IMEM_DEPTH): program-load word address.
- `ImemData`  in  32: program-load data.
- `IF_PC`  out  32: current PC.
- `ID_Inst`  out  32: IF/ID instruction register.
- `ID_PC4`  out  32: IF/ID copy of the fetched instruction's PC+4.
- `ID_Valid`  out  1: 1 = `ID_Inst` is a real fetch, 0 = bubble.

## Operation
- Fetch index is `IF_PC[log2(IMEM_DEPTH)+1:2]`.
  - Upper bits are ignored, so addressing wraps modulo the depth.
  - `IF_PC[1:0]` is ignored.
- The memory read is combinational from `IF_PC`.
- `PC4 = IF_PC + 32'd4`, computed modulo 2^32.
  - 32'hFFFF_FFFC wraps to 0.
- Jump target = `{ID_PC4[31:28], target, 2'b00}`.
  - It uses the ID-stage PC+4, not the current PC.
- Next-state priority, evaluated per clock edge:
  - `Reset`: PC←RESET_PC, ID_Inst←0, ID_PC4←0, ID_Valid←0.
  - `Branch_Taken`: PC←Branch_PC, ID_Inst←0 (NOP), ID_Valid←0. ID_PC4 holds.
  - `Jump`: PC←jump target, ID_Inst←0, ID_Valid←0. ID_PC4 holds.
  - `Stall`: PC, ID_Inst, ID_PC4 and ID_Valid all hold.
  - Otherwise: PC←PC4, ID_Inst←imem[index], ID_PC4←PC4, ID_Valid←1.
- Redirects override `Stall`.
  - A taken branch or jump in the same cycle as `Stall` still redirects and flushes.
- `Branch_Taken` and `Jump` asserted together: the branch wins, because it is the older instruction.
- Program-load port:
  - `ImemWe` writes `ImemData` to `ImemAddr` on the edge.
  - It is independent of `Reset`, `Stall` and redirects.
  - Memory contents are not cleared by `Reset`.
  - A read of the same word in the same cycle returns the old data; the new data is visible from the next cycle.

## Timing
- Reset values: `IF_PC` = RESET_PC; `ID_Inst` = 0; `ID_PC4` = 0; `ID_Valid` = 0.
- Latency: the word at PC A appears on `ID_Inst` one cycle after `IF_PC` == A.
- First edge after `Reset` deasserts:
  - `ID_Inst` = imem[RESET_PC index], `ID_Valid` = 1, `IF_PC` = RESET_PC+4.
- Reset asserted mid-operation: on that edge the pending stall, jump and branch are discarded and all outputs return to their reset values.
- Redirect penalty:
  - Jump: one bubble in ID.
  - Taken branch: one bubble from this block. Squashing the instruction already in ID is the hazard unit's job.
- During `Stall` the outputs stay constant for every stalled cycle. Fetch resumes with the held PC on the first unstalled edge.
- No combinational path from any input to `ID_*`. `IF_PC` is a register output.

## Test plan
- Reset and sequential fetch.
  - Stimulus: load imem[0..3] = 32'h11111111..32'h44444444; hold Reset 2 cycles, then release.
  - Required: ID_Inst = 11111111, 22222222, 33333333, 44444444 on successive edges; ID_PC4 = 4, 8, 12, 16; ID_Valid = 1.
- Stall.
  - Stimulus: assert Stall for 3 cycles while IF_PC = 8.
  - Required: IF_PC stays 8 and ID_Inst stays 22222222 for 3 cycles; 33333333 appears on the first edge after Stall drops.
- Jump.
  - Stimulus: Jump = 1, target = 26'h000010, ID_PC4 = 32'h0000_0008.
  - Required: next IF_PC = 32'h0000_0040, ID_Inst = 0, ID_Valid = 0; the following edge gives ID_Inst = imem[16].
- Branch versus jump, with stall.
  - Stimulus: Branch_Taken = 1, Branch_PC = 32'h0000_0020, Jump = 1, Stall = 1, all in the same cycle.
  - Required: IF_PC = 32'h20, bubble in ID; the branch wins and the stall is ignored.
- Wrap and program-load write.
  - Stimulus: IMEM_DEPTH = 256 and PC = 32'h0000_03FC; separately, ImemWe writes word 5 while IF_PC = 20.
  - Required: the next fetch index is 0 with IF_PC = 32'h400, and word 400 aliases to index 0. The write cycle returns the old word; the new word is seen on the next read.
- Reset mid-jump.
  - Stimulus: Reset = 1 and Jump = 1 in the same cycle.
  - Required: IF_PC = RESET_PC, ID_Inst = 0, ID_PC4 = 0, ID_Valid = 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// and the IF/ID pipeline register, with branch/jump redirects and stall holds.
module if_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          Stall,
  input  logic                          Jump,
  input  logic [25:0]                   target,
  input  logic                          Branch_Taken,
  input  logic [31:0]                   Branch_PC,
  input  logic                          ImemWe,
  input  logic [$clog2(IMEM_DEPTH)-1:0] ImemAddr,
  input  logic [31:0]                   ImemData,
  output logic [31:0]                   IF_PC,
  output logic [31:0]                   ID_Inst,
  output logic [31:0]                   ID_PC4,
  output logic                          ID_Valid
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_reg,    pc_next;
  logic [31:0] inst_reg,  inst_next;
  logic [31:0] pc4_reg,   pc4_next;
  logic        valid_reg, valid_next;

  logic [31:0]   pc4;
  logic [31:0]   jump_pc;
  logic [AW-1:0] fetch_idx;
  logic [31:0]   fetch_word;

  assign pc4        = pc_reg + 32'd4;
  // Jump region comes from the instruction in ID, not from the current fetch PC.
  assign jump_pc    = {pc4_reg[31:28], target, 2'b00};
  assign fetch_idx  = pc_reg[AW+1:2];
  assign fetch_word = imem[fetch_idx];

  always_comb begin
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    pc4_next   = pc4_reg;
    valid_next = valid_reg;
    // Branch is the older instruction, so it beats a jump; both beat a stall.
    if (Branch_Taken) begin
      pc_next    = Branch_PC;
      inst_next  = 32'd0;
      valid_next = 1'b0;
    end else if (Jump) begin
      pc_next    = jump_pc;
      inst_next  = 32'd0;
      valid_next = 1'b0;
    end else if (!Stall) begin
      pc_next    = pc4;
      inst_next  = fetch_word;
      pc4_next   = pc4;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'd0;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      pc4_reg   <= pc4_next;
      valid_reg <= valid_next;
    end
  end

  // Program load is untouched by reset so a loaded image survives restarts.
  always_ff @(posedge CLK) begin
    if (ImemWe) begin
      imem[ImemAddr] <= ImemData;
    end
  end

  assign IF_PC    = pc_reg;
  assign ID_Inst  = inst_reg;
  assign ID_PC4   = pc4_reg;
  assign ID_Valid = valid_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, jump, branch priority, wrap,
// program-load ordering and reset during a redirect.
module tb_if_stage;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Jump;
  logic [25:0] target;
  logic        Branch_Taken;
  logic [31:0] Branch_PC;
  logic        ImemWe;
  logic [7:0]  ImemAddr;
  logic [31:0] ImemData;
  logic [31:0] IF_PC;
  logic [31:0] ID_Inst;
  logic [31:0] ID_PC4;
  logic        ID_Valid;

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  always #5 CLK = ~CLK;

  if_stage #(
    .IMEM_DEPTH(256),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Stall       (Stall),
    .Jump        (Jump),
    .target      (target),
    .Branch_Taken(Branch_Taken),
    .Branch_PC   (Branch_PC),
    .ImemWe      (ImemWe),
    .ImemAddr    (ImemAddr),
    .ImemData    (ImemData),
    .IF_PC       (IF_PC),
    .ID_Inst     (ID_Inst),
    .ID_PC4      (ID_PC4),
    .ID_Valid    (ID_Valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 ns later and compare all four outputs.
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] pc4, input logic valid);
    @(posedge CLK);
    #1;
    step_no++;
    $display("step %0d %s: IF_PC=%h ID_Inst=%h ID_PC4=%h ID_Valid=%b",
             step_no, tag, IF_PC, ID_Inst, ID_PC4, ID_Valid);
    check({tag, ".IF_PC"},    IF_PC,   pc);
    check({tag, ".ID_Inst"},  ID_Inst, inst);
    check({tag, ".ID_PC4"},   ID_PC4,  pc4);
    check({tag, ".ID_Valid"}, {31'd0, ID_Valid}, {31'd0, valid});
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    ImemAddr = addr;
    ImemData = data;
    ImemWe   = 1'b1;
    @(posedge CLK);
    #1;
    ImemWe   = 1'b0;
    $display("load imem[%0d] = %h", addr, data);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Jump = 1'b0; target = 26'd0;
    Branch_Taken = 1'b0; Branch_PC = 32'd0;
    ImemWe = 1'b0; ImemAddr = 8'd0; ImemData = 32'd0;

    // Program load while held in reset (memory port ignores Reset).
    load(8'd0,   32'h1111_1111);
    load(8'd1,   32'h2222_2222);
    load(8'd2,   32'h3333_3333);
    load(8'd3,   32'h4444_4444);
    load(8'd5,   32'h5555_5555);
    load(8'd8,   32'h8888_8888);
    load(8'd16,  32'h1616_1616);
    load(8'd255, 32'hFFFF_00FF);

    step("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    Reset = 1'b0;

    // Sequential fetch
    step("fetch0", 32'h4, 32'h1111_1111, 32'h4, 1'b1);
    step("fetch1", 32'h8, 32'h2222_2222, 32'h8, 1'b1);

    // Stall at IF_PC = 8 for three cycles
    Stall = 1'b1;
    step("stall1", 32'h8, 32'h2222_2222, 32'h8, 1'b1);
    step("stall2", 32'h8, 32'h2222_2222, 32'h8, 1'b1);
    step("stall3", 32'h8, 32'h2222_2222, 32'h8, 1'b1);
    Stall = 1'b0;
    step("resume", 32'hC,  32'h3333_3333, 32'hC,  1'b1);
    step("fetch3", 32'h10, 32'h4444_4444, 32'h10, 1'b1);

    // Jump: {ID_PC4[31:28]=0, 26'h10, 00} = 0x40
    Jump = 1'b1; target = 26'h000010;
    step("jump", 32'h40, 32'h0, 32'h10, 1'b0);
    Jump = 1'b0;
    step("jump_fetch", 32'h44, 32'h1616_1616, 32'h44, 1'b1);

    // Branch + jump + stall together: branch wins, stall ignored
    Branch_Taken = 1'b1; Branch_PC = 32'h20; Jump = 1'b1; target = 26'h30; Stall = 1'b1;
    step("br_jmp_stall", 32'h20, 32'h0, 32'h44, 1'b0);
    Branch_Taken = 1'b0; Jump = 1'b0; Stall = 1'b0;
    step("br_fetch", 32'h24, 32'h8888_8888, 32'h24, 1'b1);

    // Index wrap: 0x3FC -> index 255, 0x400 aliases to index 0
    Branch_Taken = 1'b1; Branch_PC = 32'h3FC;
    step("br_3fc", 32'h3FC, 32'h0, 32'h24, 1'b0);
    Branch_Taken = 1'b0;
    step("fetch_3fc", 32'h400, 32'hFFFF_00FF, 32'h400, 1'b1);
    step("fetch_400", 32'h404, 32'h1111_1111, 32'h404, 1'b1);

    // Write word 5 while fetching it: old data this cycle, new data later
    Branch_Taken = 1'b1; Branch_PC = 32'h14;
    step("br_14", 32'h14, 32'h0, 32'h404, 1'b0);
    Branch_Taken = 1'b0;
    ImemWe = 1'b1; ImemAddr = 8'd5; ImemData = 32'h5A5A_5A5A;
    step("wr_same", 32'h18, 32'h5555_5555, 32'h18, 1'b1);
    ImemWe = 1'b0;
    Branch_Taken = 1'b1; Branch_PC = 32'h14;
    step("br_14b", 32'h14, 32'h0, 32'h18, 1'b0);
    Branch_Taken = 1'b0;
    step("rd_new", 32'h18, 32'h5A5A_5A5A, 32'h18, 1'b1);

    // PC+4 wraps modulo 2^32
    Branch_Taken = 1'b1; Branch_PC = 32'hFFFF_FFFC;
    step("br_top", 32'hFFFF_FFFC, 32'h0, 32'h18, 1'b0);
    Branch_Taken = 1'b0;
    step("pc_wrap", 32'h0, 32'hFFFF_00FF, 32'h0, 1'b1);

    // Jump keeps the region bits of ID_PC4
    Branch_Taken = 1'b1; Branch_PC = 32'h7000_0000;
    step("br_7000", 32'h7000_0000, 32'h0, 32'h0, 1'b0);
    Branch_Taken = 1'b0;
    step("fetch_7000", 32'h7000_0004, 32'h1111_1111, 32'h7000_0004, 1'b1);
    Jump = 1'b1; target = 26'h000010;
    step("jump_region", 32'h7000_0040, 32'h0, 32'h7000_0004, 1'b0);
    Jump = 1'b0;
    step("fetch_region", 32'h7000_0044, 32'h1616_1616, 32'h7000_0044, 1'b1);

    // Reset together with jump, branch and stall
    Reset = 1'b1; Jump = 1'b1; Branch_Taken = 1'b1; Branch_PC = 32'h20; Stall = 1'b1;
    step("reset_mid", 32'h0, 32'h0, 32'h0, 1'b0);
    Reset = 1'b0; Jump = 1'b0; Branch_Taken = 1'b0; Stall = 1'b0;
    step("post_reset", 32'h4, 32'h1111_1111, 32'h4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
